// File: rtl/jogo_pkg.sv
// Shared types and constant helpers for the sequence-memory game.
// Latency: none (types and constant functions only).
// Backpressure: none.
package jogo_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    ESPERA      = 4'h2,
    COMPARA     = 4'h4,
    PROXIMO     = 4'h5,
    FIM_RODADA  = 4'h6,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } estado_t;

  // Ceiling log2. Callers always pass values >= 2, so the result is >= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  // Sequence word i: one-hot bit ((3*i+1) mod n). Eight bits cover the widest key set.
  function automatic logic [7:0] seq_word(input int i, input int n);
    return 8'b1 << ((3 * i + 1) % n);
  endfunction

endpackage

// File: rtl/rom_sequencia.sv
// Fixed one-hot sequence ROM built from constant table entries.
// Latency: combinational read, zero cycles.
// Backpressure: none; the output always reflects the current address.
module rom_sequencia
  import jogo_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int N_CHAVES = 4,
  localparam int ADDR_W  = clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0]   addr,
  output logic [N_CHAVES-1:0] dado
);

  logic [N_CHAVES-1:0] tabela [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_tabela
    localparam logic [7:0] WORD = seq_word(g, N_CHAVES);
    assign tabela[g] = WORD[N_CHAVES-1:0];
  end

  // DEPTH is a power of two, so every address value selects a valid entry.
  assign dado = tabela[addr];

endmodule

// File: rtl/jogo_sequencia_param.sv
// Growing-round memory game: round r replays sequence entries 0..r, with an inactivity timeout.
// Latency: key edge in ESPERA -> COMPARA next cycle -> verdict state -> back in ESPERA three cycles after the edge.
// Backpressure: none; a held key yields one move, and the key must return to zero before the next move counts.
module jogo_sequencia_param
  import jogo_pkg::*;
#(
  parameter int N_CHAVES = 4,
  parameter int DEPTH    = 16,
  parameter int TIMEOUT  = 5000,
  localparam int ADDR_W  = clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [N_CHAVES-1:0] chaves,
  output logic                acertou,
  output logic                errou,
  output logic                pronto,
  output logic                timeout,
  output logic [N_CHAVES-1:0] leds,
  output logic                db_igual,
  output logic                db_tem_jogada,
  output logic [ADDR_W-1:0]   db_contagem,
  output logic [ADDR_W-1:0]   db_rodada,
  output logic [N_CHAVES-1:0] db_memoria,
  output logic [N_CHAVES-1:0] db_jogada,
  output logic [3:0]          db_estado
);

  localparam int CNT_W = clog2(TIMEOUT);
  localparam logic [ADDR_W-1:0] ULTIMA_RODADA = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_LIMITE    = CNT_W'(TIMEOUT - 1);

  estado_t             estado;
  estado_t             prox;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   rodada;
  logic [N_CHAVES-1:0] jogada_reg;
  logic [N_CHAVES-1:0] memoria;
  logic [CNT_W-1:0]    cnt;
  logic                prev_zero;
  logic                tem_jogada;
  logic                igual;

  rom_sequencia #(
    .DEPTH    (DEPTH),
    .N_CHAVES (N_CHAVES)
  ) u_rom (
    .addr (addr),
    .dado (memoria)
  );

  // A move is the first non-zero key cycle after an all-released cycle.
  assign tem_jogada = (chaves != '0) && prev_zero;
  assign igual      = (jogada_reg == memoria);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) estado <= INICIAL;
    else       estado <= prox;
  end

  // Next-state logic; a key edge in ESPERA wins over the timeout in the same cycle.
  always_comb begin
    prox = estado;
    case (estado)
      INICIAL:     if (iniciar) prox = PREPARA;
      PREPARA:     prox = ESPERA;
      ESPERA: begin
        if (tem_jogada)             prox = COMPARA;
        else if (cnt == CNT_LIMITE) prox = FIM_TIMEOUT;
      end
      COMPARA: begin
        if (!igual)                prox = FIM_ERRO;
        else if (addr == rodada)   prox = FIM_RODADA;
        else                       prox = PROXIMO;
      end
      PROXIMO:     prox = ESPERA;
      FIM_RODADA:  prox = (rodada == ULTIMA_RODADA) ? FIM_ACERTO : ESPERA;
      FIM_ACERTO,
      FIM_ERRO,
      FIM_TIMEOUT: if (iniciar) prox = PREPARA;
      default:     prox = INICIAL;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    acertou = 1'b0;
    errou   = 1'b0;
    pronto  = 1'b0;
    timeout = 1'b0;
    case (estado)
      FIM_ACERTO: begin
        acertou = 1'b1;
        pronto  = 1'b1;
      end
      FIM_ERRO: begin
        errou  = 1'b1;
        pronto = 1'b1;
      end
      FIM_TIMEOUT: begin
        errou   = 1'b1;
        timeout = 1'b1;
        pronto  = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: edge tracking, captured move, address/round counters and inactivity counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_zero  <= 1'b0;
      jogada_reg <= '0;
      addr       <= '0;
      rodada     <= '0;
      cnt        <= '0;
    end else begin
      prev_zero <= (chaves == '0);

      // The move is captured on its edge in any state; otherwise a new game wipes it.
      if (tem_jogada)             jogada_reg <= chaves;
      else if (estado == PREPARA) jogada_reg <= '0;

      // Counts only while staying in ESPERA, so every exit leaves it cleared.
      if (estado == ESPERA && prox == ESPERA) cnt <= cnt + CNT_W'(1);
      else                                     cnt <= '0;

      case (estado)
        PREPARA: begin
          addr   <= '0;
          rodada <= '0;
        end
        PROXIMO: addr <= addr + ADDR_W'(1);
        FIM_RODADA: begin
          if (rodada != ULTIMA_RODADA) begin
            rodada <= rodada + ADDR_W'(1);
            addr   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign leds          = chaves;
  assign db_igual      = igual;
  assign db_tem_jogada = tem_jogada;
  assign db_contagem   = addr;
  assign db_rodada     = rodada;
  assign db_memoria    = memoria;
  assign db_jogada     = jogada_reg;
  assign db_estado     = estado;

endmodule
